// File: rtl/uart_tx_fifo.sv
// UART transmitter with baud divider and write FIFO; frames run back-to-back.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_BITS-1:0]             txbyte,
    input  logic                             senddata,
    output logic                             ready,
    output logic                             tx,
    output logic                             txdone,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    logic [BW-1:0]          baud_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
`ifdef UART_TX_PARITY_EN
    logic                   par;
`endif

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   push;
    logic                   pop;
    logic                   empty;
    logic                   bit_end;
    logic                   frame_end;

    assign ready     = fifo_count < DEPTH;
    assign push      = senddata && ready;
    assign empty     = fifo_count == '0;
    assign bit_end   = baud_cnt == BAUD_LAST;
    assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
    // The FSM only takes a byte when it is idle or closing a frame.
    assign pop       = !empty && ((state == IDLE) || frame_end);
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= txbyte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            txdone   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            txdone <= 1'b0;
            if (state == IDLE || bit_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        par     <= (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
`endif
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= par;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            txdone  <= 1'b1;
                            bit_cnt <= '0;
                            // Chain straight into the next start bit when data waits.
                            if (pop) begin
                                shreg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                                par   <= (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
`endif
                                tx    <= 1'b0;
                                state <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8-bit/1-stop instance plus a 7-bit/2-stop instance.
// Frame vectors hold the expected line level per bit, start bit in bit 0.
module tb_uart_tx_fifo;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 11;
    localparam int NB7 = 11;
`else
    localparam int NB  = 10;
    localparam int NB7 = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] txbyte;
    logic       senddata;
    logic       ready, tx, txdone, busy;
    logic [2:0] fifo_count;

    logic [6:0] txbyte7;
    logic       senddata7;
    logic       ready7, tx7, txdone7, busy7;
    logic [2:0] fifo_count7;

    logic sel = 1'b0;
    logic tx_s, txdone_s;
    assign tx_s     = sel ? tx7 : tx;
    assign txdone_s = sel ? txdone7 : txdone;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1),
        .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst(rst), .txbyte(txbyte), .senddata(senddata),
        .ready(ready), .tx(tx), .txdone(txdone), .busy(busy),
        .fifo_count(fifo_count)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2),
        .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut7 (
        .clk(clk), .rst(rst), .txbyte(txbyte7), .senddata(senddata7),
        .ready(ready7), .tx(tx7), .txdone(txdone7), .busy(busy7),
        .fifo_count(fifo_count7)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  data;
        logic [11:0] bits;
        int          nb;
    } vec_t;

    vec_t vt[7];
    logic [11:0] seq3[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered just after a negedge; gap_max=0 demands the start bit right now.
    task automatic check_frame(input string nm, input logic [11:0] bits,
                               input int nb, input int gap_max);
        int t = 0;
        int errs = 0;
        while (tx_s !== 1'b0 && t < gap_max) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " start"}, {31'd0, tx_s}, 32'd0);
        if (tx_s !== 1'b0)
            return;
        for (int i = 0; i < nb * C; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (txdone_s !== 1'b0)
                    errs++;
            end
            if (tx_s !== bits[i / C])
                errs++;
        end
        chk({nm, " bits"}, errs, 0);
        @(negedge clk);
        chk({nm, " txdone"}, {31'd0, txdone_s}, 32'd1);
    endtask

    task automatic write1(input logic [7:0] d);
        @(negedge clk);
        txbyte   = d;
        senddata = 1'b1;
        @(negedge clk);
        senddata = 1'b0;
    endtask

    initial begin
`ifdef UART_TX_PARITY_EN
        vt[0] = '{8'h55, 12'b0_1_0_01010101_0, NB};
        vt[1] = '{8'h00, 12'b0_1_0_00000000_0, NB};
        vt[2] = '{8'hFF, 12'b0_1_0_11111111_0, NB};
        vt[3] = '{8'h81, 12'b0_1_0_10000001_0, NB};
        vt[4] = '{8'hA5, 12'b0_1_0_10100101_0, NB};
        vt[5] = '{8'h3C, 12'b0_1_0_00111100_0, NB};
        vt[6] = '{8'h07, 12'b0_1_1_00000111_0, NB};
        seq3[0] = 12'b0_1_0_00000000_0;
        seq3[1] = 12'b0_1_1_00000001_0;
        seq3[2] = 12'b0_1_1_00000010_0;
        seq3[3] = 12'b0_1_0_00000011_0;
        seq3[4] = 12'b0_1_1_00000100_0;
`else
        vt[0] = '{8'h55, 12'b00_1_01010101_0, NB};
        vt[1] = '{8'h00, 12'b00_1_00000000_0, NB};
        vt[2] = '{8'hFF, 12'b00_1_11111111_0, NB};
        vt[3] = '{8'h81, 12'b00_1_10000001_0, NB};
        vt[4] = '{8'hA5, 12'b00_1_10100101_0, NB};
        vt[5] = '{8'h3C, 12'b00_1_00111100_0, NB};
        vt[6] = '{8'h07, 12'b00_1_00000111_0, NB};
        seq3[0] = 12'b00_1_00000000_0;
        seq3[1] = 12'b00_1_00000001_0;
        seq3[2] = 12'b00_1_00000010_0;
        seq3[3] = 12'b00_1_00000011_0;
        seq3[4] = 12'b00_1_00000100_0;
`endif

        rst       = 1'b1;
        txbyte    = '0;
        senddata  = 1'b0;
        txbyte7   = '0;
        senddata7 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tx", {31'd0, tx}, 32'd1);
        chk("rst txdone", {31'd0, txdone}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst count", {29'd0, fifo_count}, 32'd0);
        chk("rst tx7", {31'd0, tx7}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle tx", {31'd0, tx}, 32'd1);

        // Single frames from the table
        for (int i = 0; i < 7; i++) begin
            write1(vt[i].data);
            chk($sformatf("v%0d count", i), {29'd0, fifo_count}, 32'd1);
            chk($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
            check_frame($sformatf("v%0d", i), vt[i].bits, vt[i].nb, 4);
            chk($sformatf("v%0d idle", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d txhi", i), {31'd0, tx}, 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d pulse", i), {31'd0, txdone}, 32'd0);
        end

        // Three back-to-back frames
        fork
            begin
                @(negedge clk); txbyte = 8'hA5; senddata = 1'b1;
                @(negedge clk); txbyte = 8'h3C;
                @(negedge clk); txbyte = 8'hFF;
                @(negedge clk); senddata = 1'b0;
            end
            begin
                @(negedge clk);
                @(negedge clk);
                check_frame("b2b A5", vt[4].bits, NB, 4);
                check_frame("b2b 3C", vt[5].bits, NB, 0);
                check_frame("b2b FF", vt[2].bits, NB, 0);
            end
        join
        chk("b2b idle", {31'd0, busy}, 32'd0);

        // Overfill: byte 5 must be dropped
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (k == 5) begin
                        chk("full ready", {31'd0, ready}, 32'd0);
                        chk("full count", {29'd0, fifo_count}, 32'd4);
                    end
                    txbyte   = 8'(k);
                    senddata = 1'b1;
                end
                @(negedge clk);
                senddata = 1'b0;
                chk("drop count", {29'd0, fifo_count}, 32'd4);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                for (int f = 0; f < 5; f++)
                    check_frame($sformatf("seq %0d", f), seq3[f], NB, (f == 0) ? 4 : 0);
            end
        join
        chk("seq idle", {31'd0, busy}, 32'd0);
        chk("seq tx", {31'd0, tx}, 32'd1);

        // Reset in the middle of data bit 3
        @(negedge clk); txbyte = 8'h12; senddata = 1'b1;
        @(negedge clk); txbyte = 8'h34;
        @(negedge clk); senddata = 1'b0;
        chk("mid start", {31'd0, tx}, 32'd0);
        repeat (17) @(negedge clk);
        chk("mid queued", {29'd0, fifo_count}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst tx", {31'd0, tx}, 32'd1);
        chk("mid rst count", {29'd0, fifo_count}, 32'd0);
        chk("mid rst busy", {31'd0, busy}, 32'd0);
        chk("mid rst ready", {31'd0, ready}, 32'd1);
        chk("mid rst txdone", {31'd0, txdone}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 24; i++) begin
                @(negedge clk);
                if (tx !== 1'b1 || txdone !== 1'b0 || busy !== 1'b0)
                    bad++;
            end
            chk("post rst quiet", bad, 0);
        end
        write1(8'h81);
        check_frame("post rst 81", vt[3].bits, NB, 4);
        chk("post rst idle", {31'd0, busy}, 32'd0);

        // 7 data bits, 2 stop bits
        sel = 1'b1;
        @(negedge clk);
        txbyte7   = 7'h7F;
        senddata7 = 1'b1;
        @(negedge clk);
        senddata7 = 1'b0;
`ifdef UART_TX_PARITY_EN
        check_frame("d7s2", 12'b0_11_1_1111111_0, NB7, 4);
`else
        check_frame("d7s2", 12'b00_11_1111111_0, NB7, 4);
`endif
        chk("d7s2 idle", {31'd0, busy7}, 32'd0);
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
